sha2_stream_pad: RTL and testbench

Streaming SHA-2 message padder with byte-granular message length, generalised over word width and SHA-2 mode. Sits between the message source and the SHA-2 core's block loader. It accepts a valid/ready word stream terminated by `in_last` and emits complete, padded 512/1024-bit blocks as a word stream. It counts the message length internally, inserts the `0x80` marker and zero fill, appends the length field, and spills into an extra block when the length field does not fit.

---
 rtl/sha2_stream_pad_pkg.sv | 27 ++
 rtl/sha2_stream_pad_if.sv | 30 +++
 rtl/sha2_stream_pad_word.sv | 26 ++
 rtl/sha2_stream_pad.sv | 109 ++++++++++
 tb/tb_sha2_stream_pad.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha2_stream_pad_pkg.sv
// Shared definitions for the streaming SHA-2 message padder: FSM states,
// block geometry constants and mode helpers.
package sha2_pkg;

    localparam int         W          = 16;
    localparam int         LEN_HI_IDX = 14;
    localparam int         LEN_LO_IDX = 15;
    localparam logic [7:0] MARKER     = 8'h80;

    typedef enum logic [2:0] {
        DATA,
        PAD,
        ZERO,
        LEN_HI,
        LEN_LO
    } pad_state_t;

    // 384/512 use 1024-bit blocks; every other mode value behaves as 256.
    function automatic int block_size(input int mode);
        return (mode == 384 || mode == 512) ? 1024 : 512;
    endfunction

    function automatic int width_for_mode(input int mode);
        return block_size(mode) / W;
    endfunction

endpackage

// File: rtl/sha2_stream_pad_if.sv
// Word-stream bundle between message source, padder and SHA-2 block loader.
interface sha2_stream_pad_if
    import sha2_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    localparam int BW = $clog2(WIDTH / 8 + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [BW-1:0]        in_bytes;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [$clog2(W)-1:0] out_idx;
    logic                 out_msg_end;

    modport master (
        output in_valid, in_data, in_bytes, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_msg_end
    );

    modport slave (
        input  in_valid, in_data, in_bytes, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_msg_end
    );

endinterface

// File: rtl/sha2_stream_pad_word.sv
// Masks the unused tail of the final message word and drops the 0x80 marker
// into the first free byte position (big-endian, byte 0 = MSB).
module sha2_pad_word
    import sha2_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]                 i_data,
    input  logic [$clog2(WIDTH/8+1)-1:0]     i_bytes,
    output logic [WIDTH-1:0]                 o_word
);
    localparam int BPW = WIDTH / 8;

    always_comb begin
        // NOTE: default first so every path assigns o_word and no latch is inferred.
        o_word = '0;
        for (int k = 0; k < BPW; k++) begin
            if (k < int'(i_bytes)) begin
                o_word[WIDTH-1-8*k -: 8] = i_data[WIDTH-1-8*k -: 8];
            end else if (k == int'(i_bytes)) begin
                o_word[WIDTH-1-8*k -: 8] = MARKER;
            end
        end
    end

endmodule

// File: rtl/sha2_stream_pad.sv
// Streaming SHA-2 padder: passes message words, then emits marker, zero fill
// and the 2*WIDTH-bit big-endian bit length to complete the final block.
module sha2_stream_pad
    import sha2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MODE  = 256
) (
    input logic              clk,
    input logic              reset,
    sha2_stream_pad_if.slave bus
);
    localparam int         BPW          = WIDTH / 8;
    localparam int         BW           = $clog2(BPW + 1);
    localparam int         LEN_W        = 2 * WIDTH;
    localparam logic [3:0] FILL_END_IDX = 4'(LEN_HI_IDX - 1);

    // The datapath follows WIDTH; a MODE that disagrees with it changes nothing.
    if (block_size(MODE) != W * WIDTH) begin : g_mode_width_mismatch
    end

    pad_state_t       r_state;
    logic [LEN_W-4:0] r_nbytes;
    logic [3:0]       r_idx;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [3:0]       r_out_idx;
    logic             r_out_msg_end;

    logic             w_free;
    logic             w_emit;
    logic [WIDTH-1:0] w_pad_word;
    logic [WIDTH-1:0] w_marker_word;
    logic [LEN_W-1:0] w_len;

    sha2_pad_word #(.WIDTH(WIDTH)) u_pad_word (
        .i_data  (bus.in_data),
        .i_bytes (bus.in_bytes),
        .o_word  (w_pad_word)
    );

    assign w_free        = !r_out_valid || bus.out_ready;
    assign w_emit        = w_free && ((r_state != DATA) || bus.in_valid);
    assign w_marker_word = {MARKER, {(WIDTH-8){1'b0}}};
    assign w_len         = {r_nbytes, 3'b000};

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout clocked logic so every register
        // samples pre-edge values; later assignments in the same edge take priority.
        if (!reset) begin
            r_state       <= DATA;
            r_nbytes      <= '0;
            r_idx         <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_idx     <= '0;
            r_out_msg_end <= 1'b0;
        end else begin
            if (w_free) begin
                r_out_valid   <= w_emit;
                r_out_msg_end <= 1'b0;
            end
            if (w_emit) begin
                r_out_idx <= r_idx;
                r_idx     <= r_idx + 4'd1;
                case (r_state)
                    DATA: begin
                        r_out_data <= bus.in_last ? w_pad_word : bus.in_data;
                        r_nbytes   <= r_nbytes + (LEN_W-3)'(bus.in_bytes);
                        if (bus.in_last) begin
                            if (bus.in_bytes == BW'(BPW))
                                r_state <= PAD;
                            else
                                r_state <= (r_idx == FILL_END_IDX) ? LEN_HI : ZERO;
                        end
                    end
                    PAD: begin
                        r_out_data <= w_marker_word;
                        r_state    <= (r_idx == FILL_END_IDX) ? LEN_HI : ZERO;
                    end
                    ZERO: begin
                        r_out_data <= '0;
                        if (r_idx == FILL_END_IDX)
                            r_state <= LEN_HI;
                    end
                    LEN_HI: begin
                        r_out_data <= w_len[LEN_W-1:WIDTH];
                        r_state    <= LEN_LO;
                    end
                    LEN_LO: begin
                        r_out_data    <= w_len[WIDTH-1:0];
                        r_out_msg_end <= 1'b1;
                        r_nbytes      <= '0;
                        r_idx         <= '0;
                        r_state       <= DATA;
                    end
                    default: r_state <= DATA;
                endcase
            end
        end
    end

    assign bus.in_ready    = reset && (r_state == DATA) && w_free;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_idx     = r_out_idx;
    assign bus.out_msg_end = r_out_msg_end;

endmodule

// File: tb/tb_sha2_stream_pad.sv
// Self-checking bench: fixed vectors, randomized messages under backpressure,
// and a byte-level padding model for the 32-bit and 64-bit padders.
module tb_sha2_stream_pad;
    import sha2_pkg::*;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [63:0] data;
        logic [3:0]  idx;
        logic        msg_end;
    } word_t;
    typedef struct {
        int          len;
        int          exp_words;
        logic [31:0] exp_lo;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sha2_stream_pad_if #(.WIDTH(32)) bus32 ();
    sha2_stream_pad_if #(.WIDTH(64)) bus64 ();

    sha2_stream_pad #(.WIDTH(32), .MODE(256)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    sha2_stream_pad #(.WIDTH(64), .MODE(512)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

    int    n_tests = 0;
    int    n_fail  = 0;
    bit    bp_en   = 1'b0;
    bit    gaps_en = 1'b0;
    word_t got32[$];
    word_t got64[$];
    word_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output-side handshake driver.
    initial begin
        bus64.out_ready = 1'b1;
        bus32.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus32.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitors: record transfers and check outputs hold while stalled.
    logic [63:0] prev_out;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        if (prev_stall)
            check("stall_hold", {27'b0, bus32.out_data, bus32.out_idx, bus32.out_msg_end}, prev_out);
        if (bus32.out_valid && bus32.out_ready)
            got32.push_back('{data: 64'(bus32.out_data), idx: bus32.out_idx, msg_end: bus32.out_msg_end});
        prev_stall = reset && bus32.out_valid && !bus32.out_ready;
        prev_out   = {27'b0, bus32.out_data, bus32.out_idx, bus32.out_msg_end};
    end

    always @(negedge clk) begin
        if (bus64.out_valid && bus64.out_ready)
            got64.push_back('{data: bus64.out_data, idx: bus64.out_idx, msg_end: bus64.out_msg_end});
    end

    // Reference: append 0x80, zero-fill to (block - length bytes), append big-endian bit length.
    task automatic build_expected(input byte_q_t msg, input int bpw);
        byte_q_t      b;
        logic [127:0] bitlen;
        logic [63:0]  w;
        int           blk, lb, nw;
        b      = msg;
        bitlen = 128'(msg.size()) * 128'd8;
        blk    = 16 * bpw;
        lb     = 2 * bpw;
        b.push_back(8'h80);
        while ((b.size() % blk) != blk - lb) b.push_back(8'h00);
        for (int i = lb - 1; i >= 0; i--) b.push_back(bitlen[8*i +: 8]);
        nw = b.size() / bpw;
        exp_q.delete();
        for (int k = 0; k < nw; k++) begin
            w = '0;
            for (int j = 0; j < bpw; j++) w = (w << 8) | 64'(b[k*bpw + j]);
            exp_q.push_back('{data: w, idx: 4'(k % 16), msg_end: (k == nw - 1)});
        end
    endtask

    function automatic byte_q_t rand_msg(input int len);
        byte_q_t m;
        for (int i = 0; i < len; i++) m.push_back(8'($urandom));
        return m;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic drive_word32(input logic [31:0] d, input int nb, input bit last);
        bit acc;
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            bus32.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus32.in_valid = 1'b1;
        bus32.in_data  = d;
        bus32.in_bytes = 3'(nb);
        bus32.in_last  = last;
        acc = 1'b0;
        for (int c = 0; c < 500 && !acc; c++) begin
            @(negedge clk);
            acc = bus32.in_ready;
            @(posedge clk); #1;
        end
        bus32.in_valid = 1'b0;
        check("in_accept", 64'(acc), 64'd1);
    endtask

    task automatic send_msg32(input byte_q_t msg);
        int          nw, nb;
        logic [31:0] d;
        nw = (msg.size() + 3) / 4;
        if (nw == 0) nw = 1;
        for (int w = 0; w < nw; w++) begin
            nb = (w == nw - 1) ? msg.size() - 4 * w : 4;
            for (int b = 0; b < 4; b++)
                d[31-8*b -: 8] = (b < nb) ? msg[4*w + b] : 8'($urandom);
            drive_word32(d, nb, w == nw - 1);
        end
    endtask

    task automatic wait_words(input bit wide, input int n);
        for (int c = 0; c < 4000; c++) begin
            if ((wide ? got64.size() : got32.size()) >= n) break;
            @(posedge clk);
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic compare_q(input string tag, input word_t got[$]);
        check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s_data[%0d]", tag, i), got[i].data, exp_q[i].data);
            check($sformatf("%s_idx[%0d]", tag, i), 64'(got[i].idx), 64'(exp_q[i].idx));
            check($sformatf("%s_end[%0d]", tag, i), 64'(got[i].msg_end), 64'(exp_q[i].msg_end));
        end
    endtask

    task automatic run_msg32(input string tag, input byte_q_t msg);
        got32.delete();
        build_expected(msg, 4);
        send_msg32(msg);
        wait_words(1'b0, exp_q.size());
        compare_q(tag, got32);
    endtask

    vec_t    vecs[9];
    byte_q_t abc;
    bit      acc64;

    initial begin
        vecs[0] = '{0,   16, 32'h0};
        vecs[1] = '{3,   16, 32'h18};
        vecs[2] = '{55,  16, 32'h1B8};
        vecs[3] = '{56,  32, 32'h1C0};
        vecs[4] = '{60,  32, 32'h1E0};
        vecs[5] = '{61,  32, 32'h1E8};
        vecs[6] = '{64,  32, 32'h200};
        vecs[7] = '{119, 32, 32'h3B8};
        vecs[8] = '{120, 48, 32'h3C0};
        abc = '{8'h61, 8'h62, 8'h63};

        bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_bytes = '0; bus32.in_last = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_bytes = '0; bus64.in_last = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_out_data", 64'(bus32.out_data), 64'd0);
        check("rst_out_idx", 64'(bus32.out_idx), 64'd0);
        check("rst_msg_end", 64'(bus32.out_msg_end), 64'd0);
        check("rst_in_ready", 64'(bus32.in_ready), 64'd0);
        check("rst_out_valid64", 64'(bus64.out_valid), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // "abc" on the 32-bit padder with hand-derived expectations.
        got32.delete();
        drive_word32(32'h61626300, 3, 1'b1);
        wait_words(1'b0, 16);
        check("abc32_count", 64'(got32.size()), 64'd16);
        if (got32.size() == 16) begin
            check("abc32_w0", got32[0].data, 64'h61626380);
            for (int i = 1; i < 15; i++) check($sformatf("abc32_zero[%0d]", i), got32[i].data, 64'h0);
            check("abc32_w15", got32[15].data, 64'h18);
            check("abc32_end14", 64'(got32[14].msg_end), 64'd0);
            check("abc32_end15", 64'(got32[15].msg_end), 64'd1);
        end

        // Length boundary table: word count and final length word from the table, contents from the model.
        for (int v = 0; v < 9; v++) begin
            run_msg32($sformatf("len%0d", vecs[v].len), rand_msg(vecs[v].len));
            check($sformatf("len%0d_words", vecs[v].len), 64'(got32.size()), 64'(vecs[v].exp_words));
            if (got32.size() > 0)
                check($sformatf("len%0d_lo", vecs[v].len), got32[got32.size()-1].data, 64'(vecs[v].exp_lo));
        end
        if (got32.size() > 0) check("len120_marker", got32[30].data, 64'h80000000);

        // Randomized messages with input gaps and output backpressure.
        for (int r = 0; r < 6; r++) begin
            gaps_en = r[0];
            bp_en   = r[1] | r[0];
            run_msg32($sformatf("rand%0d", r), rand_msg($urandom_range(0, 140)));
        end

        // Three-block message under backpressure.
        gaps_en = 1'b0;
        bp_en   = 1'b1;
        run_msg32("bp3blk", rand_msg(150));
        check("bp3blk_words", 64'(got32.size()), 64'd48);
        bp_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // "abc" on the 64-bit padder.
        got64.delete();
        bus64.in_valid = 1'b1;
        bus64.in_data  = 64'h6162630000000000;
        bus64.in_bytes = 4'd3;
        bus64.in_last  = 1'b1;
        acc64 = 1'b0;
        for (int c = 0; c < 100 && !acc64; c++) begin
            @(negedge clk);
            acc64 = bus64.in_ready;
            @(posedge clk); #1;
        end
        bus64.in_valid = 1'b0;
        check("abc64_accept", 64'(acc64), 64'd1);
        wait_words(1'b1, 16);
        check("abc64_count", 64'(got64.size()), 64'd16);
        if (got64.size() == 16) begin
            check("abc64_w0", got64[0].data, 64'h6162638000000000);
            check("abc64_w14", got64[14].data, 64'h0);
            check("abc64_w15", got64[15].data, 64'h18);
            check("abc64_end15", 64'(got64[15].msg_end), 64'd1);
        end
        build_expected(abc, 8);
        compare_q("abc64", got64);

        // Reset in the middle of a message, then a clean "abc".
        for (int i = 0; i < 5; i++) drive_word32(32'($urandom), 4, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus32.in_ready), 64'd0);
        check("midrst_out_idx", 64'(bus32.out_idx), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_msg32("midrst_abc", abc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
